// File: rtl/clint_timer.sv
// CLINT-style machine timer and software-interrupt block.
// Holds one shared prescaled 64-bit mtime, plus per-hart mtimecmp and msip registers.
// Has a single-outstanding request/response port.
module clint_timer #(
  parameter int unsigned NUM_HARTS     = 1,
  parameter int unsigned TICK_DIV      = 1,
  parameter logic [31:0] MSIP_BASE     = 32'h0200_0000,
  parameter logic [31:0] MTIMECMP_BASE = 32'h0200_2000,
  parameter logic [31:0] MTIME_BASE    = 32'h0200_1000
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_rw,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_HARTS-1:0] msip_out,
  output logic [NUM_HARTS-1:0] mtip_out
);

  localparam int unsigned PW         = 16;
  localparam int unsigned HW         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [31:0] MSIP_SPAN  = 32'(4 * NUM_HARTS);
  localparam logic [31:0] CMP_SPAN   = 32'(8 * NUM_HARTS);
  localparam logic [31:0] MTIME_SPAN = 32'd8;

  logic [PW-1:0]                presc_q, presc_d;
  logic [63:0]                  mtime_q, mtime_d, mtime_inc;
  logic [NUM_HARTS-1:0][63:0]   mtimecmp_q, mtimecmp_d;
  logic [NUM_HARTS-1:0]         msip_q, msip_d;
  logic [NUM_HARTS-1:0]         msip_out_q, mtip_out_q, mtip_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [31:0]                  rsp_rdata_q, rsp_rdata_d;
  logic                         rsp_err_q, rsp_err_d;

  logic        tick, accept, acc_err;
  logic        hit_msip, hit_cmp, hit_mtime;
  logic [31:0] off_msip, off_cmp, off_mtime;

  // Byte-lane merge used by every writable word
  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign req_ready = ~rsp_valid_q | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign tick      = (presc_q == PRESC_MAX);
  assign mtime_inc = mtime_q + 64'(tick);

  assign off_msip  = req_addr - MSIP_BASE;
  assign off_cmp   = req_addr - MTIMECMP_BASE;
  assign off_mtime = req_addr - MTIME_BASE;
  assign hit_msip  = (off_msip < MSIP_SPAN);
  assign hit_cmp   = (off_cmp < CMP_SPAN);
  assign hit_mtime = (off_mtime < MTIME_SPAN);
  assign acc_err   = (req_addr[1:0] != 2'b00) | ~(hit_msip | hit_cmp | hit_mtime);

  // Prescaler, register writes, read mux and response holding
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    mtime_d     = mtime_inc;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      if (acc_err) begin
        rsp_err_d = 1'b1;
      end else if (!req_rw) begin
        if (hit_mtime) rsp_rdata_d = off_mtime[2] ? mtime_q[63:32] : mtime_q[31:0];
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (hit_msip && (off_msip[6:2] == 5'(h))) rsp_rdata_d = {31'd0, msip_q[HW'(h)]};
          if (hit_cmp && (off_cmp[7:3] == 5'(h)))
            rsp_rdata_d = off_cmp[2] ? mtimecmp_q[HW'(h)][63:32] : mtimecmp_q[HW'(h)][31:0];
        end
      end else begin
        // A write to mtime overrides the tick on the written bytes and restarts the prescaler
        if (hit_mtime) begin
          presc_d = '0;
          if (off_mtime[2]) mtime_d[63:32] = merge_be(mtime_inc[63:32], req_wdata, req_be);
          else              mtime_d[31:0]  = merge_be(mtime_inc[31:0], req_wdata, req_be);
        end
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
          if (hit_msip && (off_msip[6:2] == 5'(h)) && req_be[0]) msip_d[HW'(h)] = req_wdata[0];
          if (hit_cmp && (off_cmp[7:3] == 5'(h))) begin
            if (off_cmp[2])
              mtimecmp_d[HW'(h)][63:32] = merge_be(mtimecmp_q[HW'(h)][63:32], req_wdata, req_be);
            else
              mtimecmp_d[HW'(h)][31:0]  = merge_be(mtimecmp_q[HW'(h)][31:0], req_wdata, req_be);
          end
        end
      end
    end
  end

  // Per-hart timer compare, unsigned 64-bit
  always_comb begin
    mtip_d = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      mtip_d[HW'(h)] = (mtime_q >= mtimecmp_q[HW'(h)]);
    end
  end

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= '0;
      msip_out_q  <= '0;
      mtip_out_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      msip_out_q  <= msip_q;
      mtip_out_q  <= mtip_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign msip_out  = msip_out_q;
  assign mtip_out  = mtip_out_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: two hart instances with TICK_DIV=1 (a) and TICK_DIV=4 (b)
// share one request bus so both see identical traffic.
module tb_clint_timer;

  localparam logic [31:0] MSIP  = 32'h0200_0000;
  localparam logic [31:0] MTCMP = 32'h0200_2000;
  localparam logic [31:0] MTIME = 32'h0200_1000;

  logic        clk_in, reset_in;
  logic        req_valid, req_rw, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_msip_out, a_mtip_out;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [1:0]  b_msip_out, b_mtip_out;

  int checks;
  int failures;

  clint_timer #(.NUM_HARTS(2), .TICK_DIV(1)) u_dut_a (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .msip_out(a_msip_out), .mtip_out(a_mtip_out)
  );

  clint_timer #(.NUM_HARTS(2), .TICK_DIV(4)) u_dut_b (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .msip_out(b_msip_out), .mtip_out(b_mtip_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reset for 3 clocks; returns at the negedge just before the first active clock
  task automatic apply_reset();
    @(negedge clk_in);
    reset_in = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // One request accepted at the next posedge (rsp_ready held high); response sampled at the following negedge
  task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rd_a, output logic er_a, output logic [31:0] rd_b, output logic vld_a);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk_in);
    rd_a = a_rsp_rdata; er_a = a_rsp_err; rd_b = b_rsp_rdata; vld_a = a_rsp_valid;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
    checks++; if (a_mtip_out !== 2'b00) begin failures++; $display("FAIL reset_mtip got=%b exp=00", a_mtip_out); end
    checks++; if (a_msip_out !== 2'b00) begin failures++; $display("FAIL reset_msip got=%b exp=00", a_msip_out); end
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
    checks++; if ({b_rsp_valid, b_rsp_err, b_mtip_out, b_msip_out} !== 6'd0)
      begin failures++; $display("FAIL reset_b_outputs got=%b exp=000000", {b_rsp_valid, b_rsp_err, b_mtip_out, b_msip_out}); end
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL reset_b_req_ready got=%b exp=1", b_req_ready); end
    repeat (9) @(negedge clk_in);
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (va !== 1'b1) begin failures++; $display("FAIL reset_read_valid got=%b exp=1", va); end
    checks++; if (ra !== 32'd9) begin failures++; $display("FAIL reset_mtime_a got=%h exp=%h", ra, 32'd9); end
    checks++; if (rb !== 32'd2) begin failures++; $display("FAIL reset_mtime_b got=%h exp=%h", rb, 32'd2); end
    checks++; if (ea !== 1'b0) begin failures++; $display("FAIL reset_read_err got=%b exp=0", ea); end
  endtask

  task automatic test_carry();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    txn(1'b1, MTIME + 32'd4, 32'h0000_0000, 4'hF, ra, ea, rb, va);
    txn(1'b1, MTIME,         32'hFFFF_FFFF, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL carry_write_rdata got=%h exp=0", ra); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_pre_lo got=%h exp=ffffffff", ra); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL carry_lo got=%h exp=0", ra); end
    txn(1'b0, MTIME + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd1) begin failures++; $display("FAIL carry_hi got=%h exp=1", ra); end
    txn(1'b1, MTIME + 32'd4, 32'hFFFF_FFFF, 4'hF, ra, ea, rb, va);
    txn(1'b1, MTIME,         32'hFFFF_FFFF, 4'hF, ra, ea, rb, va);
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre_lo got=%h exp=ffffffff", ra); end
    checks++; if (a_mtip_out !== 2'b11) begin failures++; $display("FAIL wrap_mtip_equal got=%b exp=11", a_mtip_out); end
    txn(1'b0, MTIME + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL wrap_hi got=%h exp=0", ra); end
    checks++; if (a_mtip_out !== 2'b00) begin failures++; $display("FAIL wrap_mtip_clear got=%b exp=00", a_mtip_out); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd1) begin failures++; $display("FAIL wrap_lo got=%h exp=1", ra); end
  endtask

  task automatic test_compare();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    txn(1'b1, MTCMP + 32'd12, 32'd0, 4'hF, ra, ea, rb, va);
    txn(1'b1, MTCMP + 32'd8,  32'd8, 4'hF, ra, ea, rb, va);
    repeat (6) @(negedge clk_in);
    checks++; if (a_mtip_out !== 2'b00) begin failures++; $display("FAIL cmp_before got=%b exp=00", a_mtip_out); end
    @(negedge clk_in);
    checks++; if (a_mtip_out !== 2'b10) begin failures++; $display("FAIL cmp_reach got=%b exp=10", a_mtip_out); end
    @(negedge clk_in);
    checks++; if (a_mtip_out !== 2'b10) begin failures++; $display("FAIL cmp_level got=%b exp=10", a_mtip_out); end
    txn(1'b1, MTCMP + 32'd8, 32'hFFFF_FFFF, 4'hF, ra, ea, rb, va);
    checks++; if (a_mtip_out !== 2'b10) begin failures++; $display("FAIL cmp_hold got=%b exp=10", a_mtip_out); end
    @(negedge clk_in);
    checks++; if (a_mtip_out !== 2'b00) begin failures++; $display("FAIL cmp_clear got=%b exp=00", a_mtip_out); end
  endtask

  task automatic test_msip();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    txn(1'b1, MSIP + 32'd4, 32'hFFFF_FFFF, 4'hF, ra, ea, rb, va);
    checks++; if (a_msip_out !== 2'b00) begin failures++; $display("FAIL msip_not_yet got=%b exp=00", a_msip_out); end
    txn(1'b0, MSIP + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd1) begin failures++; $display("FAIL msip_readback got=%h exp=1", ra); end
    checks++; if (a_msip_out !== 2'b10) begin failures++; $display("FAIL msip_out got=%b exp=10", a_msip_out); end
    txn(1'b0, MSIP, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL msip0_read got=%h exp=0", ra); end
    txn(1'b1, MSIP + 32'd4, 32'd0, 4'h0, ra, ea, rb, va);
    txn(1'b0, MSIP + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd1) begin failures++; $display("FAIL msip_be0 got=%h exp=1", ra); end
    txn(1'b1, MSIP + 32'd4, 32'd0, 4'h1, ra, ea, rb, va);
    txn(1'b0, MSIP + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL msip_cleared got=%h exp=0", ra); end
    checks++; if (a_msip_out !== 2'b00) begin failures++; $display("FAIL msip_out_clear got=%b exp=00", a_msip_out); end
  endtask

  task automatic test_errors();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    txn(1'b1, MSIP + 32'd1, 32'd1, 4'hF, ra, ea, rb, va);
    checks++; if ({ea, ra} !== {1'b1, 32'd0}) begin failures++; $display("FAIL err_wr_misalign got=%b/%h exp=1/0", ea, ra); end
    txn(1'b1, MSIP + 32'd8, 32'd1, 4'hF, ra, ea, rb, va);
    checks++; if (ea !== 1'b1) begin failures++; $display("FAIL err_wr_msip2 got=%b exp=1", ea); end
    txn(1'b0, MSIP + 32'd8, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({ea, ra} !== {1'b1, 32'd0}) begin failures++; $display("FAIL err_rd_msip2 got=%b/%h exp=1/0", ea, ra); end
    txn(1'b0, MTIME + 32'd1, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({ea, ra} !== {1'b1, 32'd0}) begin failures++; $display("FAIL err_rd_misalign got=%b/%h exp=1/0", ea, ra); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({ea, ra} !== {1'b0, 32'd4}) begin failures++; $display("FAIL err_mtime_ok got=%b/%h exp=0/4", ea, ra); end
    txn(1'b1, MTIME + 32'd1, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ea !== 1'b1) begin failures++; $display("FAIL err_wr_mtime_misalign got=%b exp=1", ea); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd6) begin failures++; $display("FAIL err_no_change got=%h exp=6", ra); end
    txn(1'b0, MTCMP + 32'd16, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ea !== 1'b1) begin failures++; $display("FAIL err_cmp2 got=%b exp=1", ea); end
    txn(1'b0, MTIME + 32'd8, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ea !== 1'b1) begin failures++; $display("FAIL err_mtime8 got=%b exp=1", ea); end
    txn(1'b0, MTCMP + 32'd12, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({ea, ra} !== {1'b0, 32'hFFFF_FFFF}) begin failures++; $display("FAIL err_cmp1_hi got=%b/%h exp=0/ffffffff", ea, ra); end
    checks++; if (a_msip_out !== 2'b00) begin failures++; $display("FAIL err_msip_untouched got=%b exp=00", a_msip_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rb; logic ea, va;
    logic [31:0] exp_b [5];
    exp_b = '{32'h50, 32'h50, 32'h50, 32'h50, 32'h51};
    apply_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = MTCMP; req_wdata = '0; req_be = 4'hF;
    @(negedge clk_in);
    req_addr = MTIME;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({a_rsp_valid, a_req_ready, b_req_ready} !== 3'b100)
        begin failures++; $display("FAIL bp_hold%0d valid/ready got=%b exp=100", i, {a_rsp_valid, a_req_ready, b_req_ready}); end
      checks++; if ({a_rsp_err, a_rsp_rdata} !== {1'b0, 32'hFFFF_FFFF})
        begin failures++; $display("FAIL bp_stable%0d got=%b/%h exp=0/ffffffff", i, a_rsp_err, a_rsp_rdata); end
      if (i < 2) @(negedge clk_in);
    end
    rsp_ready = 1'b1;
    @(negedge clk_in);
    req_valid = 1'b0;
    checks++; if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 32'd3}) begin failures++; $display("FAIL bp_release_a got=%b/%h exp=1/3", a_rsp_valid, a_rsp_rdata); end
    checks++; if (b_rsp_rdata !== 32'd0) begin failures++; $display("FAIL bp_release_b got=%h exp=0", b_rsp_rdata); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({ra, rb} !== {32'd4, 32'd1}) begin failures++; $display("FAIL b2b_p4 got=%h/%h exp=4/1", ra, rb); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if ({va, ra} !== {1'b1, 32'd5}) begin failures++; $display("FAIL b2b_p5 got=%b/%h exp=1/5", va, ra); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    txn(1'b1, MTIME, 32'hAABB_CC00, 4'b1110, ra, ea, rb, va);
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (rb !== 32'hAABB_CC02) begin failures++; $display("FAIL tickwr_b got=%h exp=aabbcc02", rb); end
    checks++; if (ra !== 32'hAABB_CC08) begin failures++; $display("FAIL tickwr_a got=%h exp=aabbcc08", ra); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (rb !== 32'hAABB_CC02) begin failures++; $display("FAIL presc_pre_tick got=%h exp=aabbcc02", rb); end
    txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (rb !== 32'hAABB_CC03) begin failures++; $display("FAIL presc_tick got=%h exp=aabbcc03", rb); end
    txn(1'b1, MTIME, 32'h0000_0050, 4'hF, ra, ea, rb, va);
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, MTIME, 32'd0, 4'hF, ra, ea, rb, va);
      checks++; if (rb !== exp_b[i]) begin failures++; $display("FAIL presc_restart%0d got=%h exp=%h", i, rb, exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ra, rb; logic ea, va;
    apply_reset();
    txn(1'b1, MSIP, 32'd1, 4'hF, ra, ea, rb, va);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = MTCMP; req_be = 4'hF;
    @(negedge clk_in);
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++; if (a_msip_out !== 2'b01) begin failures++; $display("FAIL mid_msip_set got=%b exp=01", a_msip_out); end
    @(negedge clk_in);
    checks++; if (a_rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_rsp_held got=%b exp=1", a_rsp_valid); end
    reset_in = 1'b1;
    @(negedge clk_in);
    checks++; if ({a_rsp_valid, a_req_ready, a_msip_out} !== 4'b0100)
      begin failures++; $display("FAIL mid_reset_drop got=%b exp=0100", {a_rsp_valid, a_req_ready, a_msip_out}); end
    reset_in = 1'b0; rsp_ready = 1'b1;
    txn(1'b0, MSIP, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'd0) begin failures++; $display("FAIL mid_msip_reset got=%h exp=0", ra); end
    txn(1'b0, MTCMP + 32'd4, 32'd0, 4'hF, ra, ea, rb, va);
    checks++; if (ra !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mid_cmp_reset got=%h exp=ffffffff", ra); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_in = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_rw = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    test_reset();
    test_carry();
    test_compare();
    test_msip();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
